seq_mult_param: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the fixed 8-bit Lab4 multiplier.

---
 rtl/seq_mult_param.sv | 105 ++++++++++
 tb/tb_seq_mult_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH-bit signed or unsigned operands, 2*WIDTH-bit product.
// One add/sub and arithmetic right-shift per clock; Start/Busy/Done handshake.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic               Xval
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_s;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_x;
  logic                 r_mode;
  logic [CW-1:0]        r_count;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_last;
  logic                 w_sub;
  logic [WIDTH:0]       w_ext_s;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic                 w_fill;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (Start) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last multiplier bit carries negative weight in two's complement, so it subtracts.
  always_comb begin
    w_last   = (r_count == LAST);
    w_sub    = r_b[0] & w_last & r_mode;
    w_ext_s  = r_mode ? {r_s[WIDTH-1], r_s} : {1'b0, r_s};
    w_addend = '0;
    if (r_b[0]) w_addend = w_sub ? ~w_ext_s : w_ext_s;
    w_sum    = {r_x, r_a} + w_addend + (WIDTH+1)'(w_sub);
    w_fill   = r_mode & w_sum[WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and
  // clears every register, so an abort mid-RUN leaves no stale partial product behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_s       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_x       <= 1'b0;
      r_mode    <= 1'b0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_s     <= Multiplicand;
            r_b     <= Multiplier;
            r_a     <= '0;
            r_x     <= 1'b0;
            r_mode  <= Signed_Mode;
            r_count <= '0;
          end
        end
        S_RUN: begin
          {r_x, r_a, r_b} <= {w_fill, w_sum, r_b[WIDTH-1:1]};
          if (!w_last) r_count <= r_count + 1'b1;
        end
        S_DONE: r_product <= {r_a, r_b};
        default: ;
      endcase
    end
  end

  assign Busy    = (r_state == S_RUN);
  assign Done    = r_done;
  assign Product = r_product;
  assign Xval    = r_x;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=8 and WIDTH=16, plus signed/unsigned
// random pairs on the 16-bit instance against an arithmetic reference.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, mode8, busy8, done8, x8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;

  logic        start16, mode16, busy16, done16, x16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Signed_Mode(mode8),
    .Multiplicand(mc8), .Multiplier(mp8),
    .Busy(busy8), .Done(done8), .Product(prod8), .Xval(x8)
  );

  seq_mult_param #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst), .Start(start16), .Signed_Mode(mode16),
    .Multiplicand(mc16), .Multiplier(mp16),
    .Busy(busy16), .Done(done16), .Product(prod16), .Xval(x16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_8(input logic m, input logic [7:0] a, input logic [7:0] b);
    mode8 = m; mc8 = a; mp8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("busy8 after start", busy8, 1);
  endtask

  task automatic wait_8(input string tag, input logic [15:0] exp, input int exp_lat);
    int n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " done"}, done8, 1);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " product"}, prod8, exp);
  endtask

  task automatic start_16(input logic m, input logic [15:0] a, input logic [15:0] b);
    mode16 = m; mc16 = a; mp16 = b; start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  task automatic wait_16(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!done16 && n < 60) begin
      tick();
      n++;
    end
    check({tag, " done"}, done16, 1);
    check({tag, " latency"}, n, 17);
    check({tag, " product"}, prod16, exp);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    logic [31:0] rexp;

    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; mc8 = '0; mp8 = '0;
    start16 = 1'b0; mode16 = 1'b0; mc16 = '0; mp16 = '0;
    tick(2);
    rst = 1'b0;
    check("reset product", prod8, 16'h0000);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset xval", x8, 0);

    // 7 * -59 signed: Done exactly WIDTH+1 edges after the Start edge.
    start_8(1'b1, 8'h07, 8'hC5);
    wait_8("s 7*-59", 16'hFE63, 9);
    check("s 7*-59 xval", x8, 1);
    check("s 7*-59 busy at done", busy8, 0);
    tick();
    check("done one cycle", done8, 0);
    check("product held", prod8, 16'hFE63);

    start_8(1'b1, 8'h80, 8'h80);
    wait_8("s min*min", 16'h4000, 9);
    start_8(1'b0, 8'hFF, 8'hFF);
    wait_8("u ff*ff", 16'hFE01, 9);
    start_8(1'b1, 8'hFF, 8'hFF);
    wait_8("s -1*-1", 16'h0001, 9);

    // Mode and operands changed mid-RUN must not disturb the captured values.
    start_8(1'b1, 8'hFF, 8'hFF);
    tick(3);
    mode8 = 1'b0; mc8 = 8'h12; mp8 = 8'h34;
    wait_8("mode toggle", 16'h0001, 6);

    // A second Start during RUN is ignored and not queued.
    start_8(1'b1, 8'h07, 8'hC5);
    tick(2);
    mc8 = 8'h11; mp8 = 8'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("busy during restart", busy8, 1);
    wait_8("ignored restart", 16'hFE63, 6);
    tick(3);
    check("no queued run", busy8, 0);

    // Reset mid-RUN aborts and clears the held product.
    start_8(1'b1, 8'h07, 8'hC5);
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort product", prod8, 16'h0000);
    start_8(1'b0, 8'h03, 8'h05);
    wait_8("u 3*5", 16'h000F, 9);

    start_16(1'b1, 16'h8000, 16'h7FFF);
    wait_16("s16 min*max", 32'hC000_8000);
    start_16(1'b0, 16'hFFFF, 16'hFFFF);
    wait_16("u16 max*max", 32'hFFFE_0001);

    for (int i = 0; i < 1000; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rm) rexp = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
      else    rexp = {16'h0000, ra} * {16'h0000, rb};
      start_16(rm, ra, rb);
      wait_16($sformatf("rand%0d %s %h*%h", i, rm ? "s" : "u", ra, rb), rexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
